// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues one instruction-bus request at
// a time, and hands fetched words to decode through an output slot backed by
// a one-entry skid buffer. Redirects from decode flush the slot and skid;
// responses to wrong-path requests already on the bus are dropped.
module fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  typedef enum logic [0:0] {
    ST_FETCH   = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  state_t      state_r;
  logic        run_r;
  logic [63:0] pc_r;
  logic [63:0] hold_addr_r;
  logic        slot_valid_r;
  logic [63:0] slot_pc_r;
  logic [31:0] slot_instr_r;
  logic        skid_valid_r;
  logic [63:0] skid_pc_r;
  logic [31:0] skid_instr_r;

  logic        ireq_valid_s;
  logic [63:0] ireq_addr_s;
  logic        consume_s;
  logic        take_redirect_s;
  logic        accept_s;
  logic [63:0] redirect_target_s;

  // Bus request derived only from state and registers; DISCARD keeps the
  // wrong-path address on the bus until its response arrives.
  always_comb begin
    ireq_valid_s = 1'b0;
    ireq_addr_s  = pc_r;
    case (state_r)
      ST_FETCH: begin
        ireq_valid_s = run_r & ~skid_valid_r;
        ireq_addr_s  = pc_r;
      end
      ST_DISCARD: begin
        ireq_valid_s = 1'b1;
        ireq_addr_s  = hold_addr_r;
      end
      default: begin
        ireq_valid_s = 1'b0;
        ireq_addr_s  = pc_r;
      end
    endcase
  end

  // Handshake qualifiers: a redirect only counts when decode consumes the slot.
  always_comb begin
    consume_s         = slot_valid_r & ~stall;
    take_redirect_s   = redirect & consume_s;
    accept_s          = iresp_data_ok & ireq_valid_s;
    redirect_target_s = redirect_pc & ~64'd3;
  end

  assign ireq_valid = ireq_valid_s;
  assign ireq_addr  = ireq_addr_s;
  assign out_valid  = slot_valid_r;
  assign out_pc     = slot_pc_r;
  assign out_instr  = slot_instr_r;

  // PC, slot, skid and FETCH/DISCARD sequencing; redirect has top priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_FETCH;
      run_r        <= 1'b0;
      pc_r         <= RESET_PC;
      hold_addr_r  <= RESET_PC;
      slot_valid_r <= 1'b0;
      slot_pc_r    <= 64'd0;
      slot_instr_r <= 32'd0;
      skid_valid_r <= 1'b0;
      skid_pc_r    <= 64'd0;
      skid_instr_r <= 32'd0;
    end else begin
      run_r <= 1'b1;
      if (take_redirect_s) begin
        pc_r         <= redirect_target_s;
        slot_valid_r <= 1'b0;
        skid_valid_r <= 1'b0;
        if (ireq_valid_s && !iresp_data_ok) begin
          state_r     <= ST_DISCARD;
          hold_addr_r <= ireq_addr_s;
        end else begin
          state_r <= ST_FETCH;
        end
      end else begin
        case (state_r)
          ST_DISCARD: begin
            if (accept_s) begin
              state_r <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            if (accept_s) begin
              pc_r <= pc_r + 64'd4;
              if (!slot_valid_r || consume_s) begin
                slot_valid_r <= 1'b1;
                slot_pc_r    <= pc_r;
                slot_instr_r <= iresp_data;
              end else begin
                skid_valid_r <= 1'b1;
                skid_pc_r    <= pc_r;
                skid_instr_r <= iresp_data;
              end
            end else if (consume_s) begin
              if (skid_valid_r) begin
                slot_valid_r <= 1'b1;
                slot_pc_r    <= skid_pc_r;
                slot_instr_r <= skid_instr_r;
                skid_valid_r <= 1'b0;
              end else begin
                slot_valid_r <= 1'b0;
              end
            end
          end
          default: begin
            state_r <= ST_FETCH;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage: streaming, stall/skid, redirects with
// and without an in-flight response, stalled redirect, and reset in DISCARD.
module tb_fetch;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  int passed;
  int total;

  fetch #(.RESET_PC(64'h0000_0000_8000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_instr     (out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic ok, input logic [31:0] data, input logic st,
                       input logic rd, input logic [63:0] rpc);
    iresp_data_ok = ok;
    iresp_data    = data;
    stall         = st;
    redirect      = rd;
    redirect_pc   = rpc;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
    cyc();
    chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("rst_ireq_addr", ireq_addr, 64'h8000_0000);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
    cyc();
    reset = 1'b0;
    cyc();
    // P1: first request
    chk("p1_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("p1_ireq_addr", ireq_addr, 64'h8000_0000);
    chk("p1_out_valid", {63'd0, out_valid}, 64'd0);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
    cyc();
    // P2: request held, response arrives
    chk("p2_ireq_addr", ireq_addr, 64'h8000_0000);
    drive(1'b1, 32'h1000_0000, 1'b0, 1'b0, 64'd0);
    cyc();
    // P3: slot holds 0, next request 4 with response streaming
    chk("p3_out_valid", {63'd0, out_valid}, 64'd1);
    chk("p3_out_pc", out_pc, 64'h8000_0000);
    chk("p3_out_instr", {32'd0, out_instr}, 64'h1000_0000);
    chk("p3_ireq_addr", ireq_addr, 64'h8000_0004);
    chk("p3_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    drive(1'b1, 32'h1000_0004, 1'b0, 1'b0, 64'd0);
    cyc();
    // P4: slot holds 4; stall while response for 8 arrives
    chk("p4_out_valid", {63'd0, out_valid}, 64'd1);
    chk("p4_out_pc", out_pc, 64'h8000_0004);
    chk("p4_out_instr", {32'd0, out_instr}, 64'h1000_0004);
    chk("p4_ireq_addr", ireq_addr, 64'h8000_0008);
    drive(1'b1, 32'h1000_0008, 1'b1, 1'b0, 64'd0);
    cyc();
    // P5..P7: stalled, skid full, no requests
    for (int i = 0; i < 3; i++) begin
      chk("stall_out_pc", out_pc, 64'h8000_0004);
      chk("stall_out_instr", {32'd0, out_instr}, 64'h1000_0004);
      chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_ireq_valid", {63'd0, ireq_valid}, 64'd0);
      drive(1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
      cyc();
    end
    // P8: still stalled state visible; release stall now
    chk("p8_out_pc", out_pc, 64'h8000_0004);
    chk("p8_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
    cyc();
    // P9: skid drained into slot, request for C issued
    chk("p9_out_pc", out_pc, 64'h8000_0008);
    chk("p9_out_instr", {32'd0, out_instr}, 64'h1000_0008);
    chk("p9_out_valid", {63'd0, out_valid}, 64'd1);
    chk("p9_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("p9_ireq_addr", ireq_addr, 64'h8000_000C);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 64'h8000_0100);
    cyc();
    // P10: DISCARD, old address held
    chk("p10_out_valid", {63'd0, out_valid}, 64'd0);
    chk("p10_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("p10_ireq_addr", ireq_addr, 64'h8000_000C);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'd0);
    cyc();
    // P11: wrong-path data dropped, new target requested
    chk("p11_out_valid", {63'd0, out_valid}, 64'd0);
    chk("p11_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("p11_ireq_addr", ireq_addr, 64'h8000_0100);
    drive(1'b1, 32'h1000_0100, 1'b0, 1'b0, 64'd0);
    cyc();
    // P12: slot at 100; redirect coincident with data_ok
    chk("p12_out_pc", out_pc, 64'h8000_0100);
    chk("p12_out_instr", {32'd0, out_instr}, 64'h1000_0100);
    chk("p12_ireq_addr", ireq_addr, 64'h8000_0104);
    drive(1'b1, 32'hBAD0_0104, 1'b0, 1'b1, 64'h8000_0100);
    cyc();
    // P13: data dropped, new request immediately
    chk("p13_out_valid", {63'd0, out_valid}, 64'd0);
    chk("p13_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("p13_ireq_addr", ireq_addr, 64'h8000_0100);
    drive(1'b1, 32'h2000_0100, 1'b0, 1'b0, 64'd0);
    cyc();
    // P14: slot at 100; redirect presented while stalled
    chk("p14_out_instr", {32'd0, out_instr}, 64'h2000_0100);
    chk("p14_ireq_addr", ireq_addr, 64'h8000_0104);
    drive(1'b0, 32'd0, 1'b1, 1'b1, 64'h8000_0102);
    cyc();
    // P15: redirect ignored; release stall with redirect still high
    chk("p15_out_valid", {63'd0, out_valid}, 64'd1);
    chk("p15_out_pc", out_pc, 64'h8000_0100);
    chk("p15_ireq_addr", ireq_addr, 64'h8000_0104);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 64'h8000_0102);
    cyc();
    // P16: redirect taken into DISCARD holding 104
    chk("p16_out_valid", {63'd0, out_valid}, 64'd0);
    chk("p16_ireq_addr", ireq_addr, 64'h8000_0104);
    drive(1'b1, 32'hDEAD_0104, 1'b0, 1'b0, 64'd0);
    cyc();
    // P17: aligned target requested
    chk("p17_out_valid", {63'd0, out_valid}, 64'd0);
    chk("p17_ireq_addr", ireq_addr, 64'h8000_0100);
    drive(1'b1, 32'h3000_0100, 1'b0, 1'b0, 64'd0);
    cyc();
    // P18: slot at 100; redirect with request pending -> DISCARD
    chk("p18_out_instr", {32'd0, out_instr}, 64'h3000_0100);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 64'h8000_0300);
    cyc();
    // P19: in DISCARD; assert reset asynchronously
    chk("p19_ireq_addr", ireq_addr, 64'h8000_0104);
    chk("p19_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
    reset = 1'b1;
    #1;
    chk("arst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("arst_ireq_addr", ireq_addr, 64'h8000_0000);
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_out_pc", out_pc, 64'd0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk("post_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("post_ireq_addr", ireq_addr, 64'h8000_0000);
    chk("post_out_valid", {63'd0, out_valid}, 64'd0);
    drive(1'b1, 32'h4000_0000, 1'b0, 1'b0, 64'd0);
    cyc();
    chk("post_out_pc", out_pc, 64'h8000_0000);
    chk("post_out_instr", {32'd0, out_instr}, 64'h4000_0000);
    chk("post_next_addr", ireq_addr, 64'h8000_0004);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
